// File: rtl/dplca_pkg.sv
// Shared DPLCA definitions: claim encodings, table geometry and control-FSM states.
// Used by the TO claim table controller and the node-ID state machine.
package dplca_pkg;

   localparam int unsigned TABLE_DEPTH    = 256;
   localparam int unsigned IDX_W          = 8;
   localparam int unsigned CLAIM_W        = 2;
   localparam int unsigned TABLE_W        = TABLE_DEPTH * CLAIM_W;
   localparam int unsigned AGE_CYCLES_DEF = 16;

   typedef enum logic [CLAIM_W-1:0] {
      FREE       = 2'b00,
      SOFT_CLAIM = 2'b01,
      HARD_CLAIM = 2'b10
   } claim_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SWEEP = 2'b01,
      DONE  = 2'b10
   } state_t;

   // One aging step for an entry with no use in the closing window; reserved decays to FREE
   function automatic logic [CLAIM_W-1:0] age_claim(input logic [CLAIM_W-1:0] c);
      return (c == HARD_CLAIM) ? SOFT_CLAIM : FREE;
   endfunction

endpackage

// File: rtl/dplca_age_counter.sv
// Modulo-AGE_CYCLES PLCA cycle counter; boundary_c flags the cycle_end that closes a window.
module dplca_age_counter
   import dplca_pkg::*;
#(
   parameter int unsigned AGE_CYCLES = AGE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic boundary_c
);

   localparam int unsigned     CNT_W    = $clog2(AGE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AGE_CYCLES - 1);

   logic [CNT_W-1:0] age_cnt;

   assign boundary_c = inc && (age_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         age_cnt <= '0;
      end else if (clr || boundary_c) begin
         age_cnt <= '0;
      end else if (inc) begin
         age_cnt <= age_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dplca_txop_table_ctrl.sv
// DPLCA transmit-opportunity claim table: records TO use, ages claims once per window
// with a one-entry-per-clock sweep, and signals when the table is consistent.
module dplca_txop_table_ctrl
   import dplca_pkg::*;
#(
   parameter int unsigned AGE_CYCLES = AGE_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               plca_reset,
   input  logic               dplca_aging,
   input  logic [IDX_W-1:0]   plca_node_count,
   input  logic               to_end,
   input  logic [IDX_W-1:0]   to_id,
   input  logic               to_used,
   input  logic               cycle_end,
   output logic [TABLE_W-1:0] txop_claim_table_unpacked,
   output logic               dplca_txop_table_upd,
   output logic               dplca_new_age,
   output logic               sweep_busy
);

   state_t                                 state;
   logic [IDX_W-1:0]                       sweep_idx;
   logic [TABLE_DEPTH-1:0][CLAIM_W-1:0]    claim_q;
   logic [TABLE_DEPTH-1:0]                 seen_q;
   logic                                   record_c;
   logic                                   boundary_c;

   assign record_c                  = to_end && to_used && (to_id < plca_node_count);
   assign txop_claim_table_unpacked = claim_q;

   dplca_age_counter #(
      .AGE_CYCLES (AGE_CYCLES)
   ) u_age_counter (
      .clk        (clk),
      .rst        (plca_reset),
      .clr        (!dplca_aging),
      .inc        (cycle_end && dplca_aging),
      .boundary_c (boundary_c)
   );

   // Table, seen bits and control FSM; recording is applied last so it wins over the sweep
   always_ff @(posedge clk or posedge plca_reset) begin
      if (plca_reset) begin
         state                <= IDLE;
         sweep_idx            <= '0;
         claim_q              <= '0;
         seen_q               <= '0;
         dplca_txop_table_upd <= 1'b0;
         dplca_new_age        <= 1'b0;
         sweep_busy           <= 1'b0;
      end else if (!dplca_aging) begin
         state                <= IDLE;
         sweep_idx            <= '0;
         claim_q              <= '0;
         seen_q               <= '0;
         dplca_txop_table_upd <= 1'b0;
         dplca_new_age        <= 1'b0;
         sweep_busy           <= 1'b0;
      end else begin
         dplca_txop_table_upd <= 1'b0;
         if (to_end) begin
            dplca_new_age <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (boundary_c) begin
                  state      <= SWEEP;
                  sweep_idx  <= '0;
                  sweep_busy <= 1'b1;
               end else if (cycle_end) begin
                  dplca_txop_table_upd <= 1'b1;
               end
            end

            // Non-boundary cycle_end pulses in here are absorbed by the DONE pulse
            SWEEP: begin
               if (seen_q[sweep_idx]) begin
                  claim_q[sweep_idx] <= HARD_CLAIM;
                  seen_q[sweep_idx]  <= 1'b0;
               end else begin
                  claim_q[sweep_idx] <= age_claim(claim_q[sweep_idx]);
               end
               sweep_idx <= sweep_idx + IDX_W'(1);
               if (sweep_idx == IDX_W'(TABLE_DEPTH - 1)) begin
                  state      <= DONE;
                  sweep_busy <= 1'b0;
               end
            end

            DONE: begin
               dplca_txop_table_upd <= 1'b1;
               dplca_new_age        <= 1'b1;
               if (boundary_c) begin
                  state      <= SWEEP;
                  sweep_idx  <= '0;
                  sweep_busy <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state      <= IDLE;
               sweep_busy <= 1'b0;
            end
         endcase

         if (record_c) begin
            claim_q[to_id] <= HARD_CLAIM;
            seen_q[to_id]  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_dplca_txop_table_ctrl.sv
// Directed bench for dplca_txop_table_ctrl: vector table for recording/clear behaviour,
// hand-written sequences for window aging, sweep collisions and mid-sweep aborts.
module tb_dplca_txop_table_ctrl;

   logic         clk;
   logic         plca_reset;
   logic         dplca_aging;
   logic [7:0]   plca_node_count;
   logic         to_end;
   logic [7:0]   to_id;
   logic         to_used;
   logic         cycle_end;
   logic [511:0] tab;
   logic         upd;
   logic         new_age;
   logic         sweep_busy;

   int n_cmp = 0;
   int n_bad = 0;

   dplca_txop_table_ctrl #(.AGE_CYCLES(16)) dut (
      .clk                       (clk),
      .plca_reset                (plca_reset),
      .dplca_aging               (dplca_aging),
      .plca_node_count           (plca_node_count),
      .to_end                    (to_end),
      .to_id                     (to_id),
      .to_used                   (to_used),
      .cycle_end                 (cycle_end),
      .txop_claim_table_unpacked (tab),
      .dplca_txop_table_upd      (upd),
      .dplca_new_age             (new_age),
      .sweep_busy                (sweep_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int ag, te, tu, id, nc, ce;
      int e_upd, e_na, e_nz, c_idx, c_val;
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int nz_count(input logic [511:0] t);
      int n = 0;
      for (int i = 0; i < 256; i++)
         if (t[2*i +: 2] != 2'b00) n++;
      return n;
   endfunction

   function automatic int entry(input logic [511:0] t, input int i);
      return int'(t[2*i +: 2]);
   endfunction

   task automatic record(input int id);
      to_end = 1'b1; to_used = 1'b1; to_id = 8'(id);
      tick();
      to_end = 1'b0; to_used = 1'b0;
   endtask

   // n non-boundary cycle ends, each giving exactly one upd pulse
   task automatic window(input int n, input int exp_na, input string tag);
      for (int k = 0; k < n; k++) begin
         cycle_end = 1'b1;
         tick();
         cycle_end = 1'b0;
         check({tag, "_upd_hi"}, int'(upd), 1);
         check({tag, "_busy"}, int'(sweep_busy), 0);
         tick();
         check({tag, "_upd_lo"}, int'(upd), 0);
      end
      check({tag, "_new_age"}, int'(new_age), exp_na);
   endtask

   // Boundary cycle_end then wait for the DONE pulse; optional record of id 5 / extra cycle_end
   task automatic do_sweep(input int rec_at, input int ce_at, input string tag);
      int  lat;
      int  busy_n;
      bit  got;
      cycle_end = 1'b1;
      tick();
      cycle_end = 1'b0;
      lat = 1; busy_n = 0; got = 1'b0;
      if (sweep_busy) busy_n++;
      while (!got && lat < 400) begin
         if (lat == rec_at) begin
            to_end = 1'b1; to_used = 1'b1; to_id = 8'd5;
         end
         if (lat == ce_at) cycle_end = 1'b1;
         tick();
         lat++;
         to_end = 1'b0; to_used = 1'b0; cycle_end = 1'b0;
         if (sweep_busy) busy_n++;
         if (upd) got = 1'b1;
      end
      check({tag, "_latency"}, lat, 258);
      check({tag, "_busy_clocks"}, busy_n, 256);
      check({tag, "_new_age"}, int'(new_age), 1);
      tick();
      check({tag, "_upd_single"}, int'(upd), 0);
      check({tag, "_new_age_hold"}, int'(new_age), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      plca_reset = 1'b1; dplca_aging = 1'b1; plca_node_count = 8'd8;
      to_end = 1'b0; to_id = 8'd0; to_used = 1'b0; cycle_end = 1'b0;

      //           ag te tu id nc ce  upd na nz idx val
      vecs[0]  = '{1, 1, 1, 3, 8, 0,  0,  0, 1, 3, 2};
      vecs[1]  = '{1, 1, 1, 9, 8, 0,  0,  0, 1, 9, 0};
      vecs[2]  = '{1, 1, 0, 4, 8, 0,  0,  0, 1, 4, 0};
      vecs[3]  = '{1, 1, 1, 7, 8, 0,  0,  0, 2, 7, 2};
      vecs[4]  = '{1, 1, 1, 8, 8, 0,  0,  0, 2, 8, 0};
      vecs[5]  = '{1, 0, 0, 0, 8, 1,  1,  0, 2, 3, 2};
      vecs[6]  = '{1, 0, 0, 0, 8, 0,  0,  0, 2, 7, 2};
      vecs[7]  = '{1, 1, 1, 0, 8, 1,  1,  0, 3, 0, 2};
      vecs[8]  = '{1, 1, 1, 2, 2, 0,  0,  0, 3, 2, 0};
      vecs[9]  = '{1, 1, 1, 1, 2, 0,  0,  0, 4, 1, 2};
      vecs[10] = '{0, 1, 1, 2, 8, 1,  0,  0, 0, 2, 0};
      vecs[11] = '{1, 0, 0, 0, 8, 0,  0,  0, 0, 3, 0};

      tick();
      tick();
      check("rst_table_nz", nz_count(tab), 0);
      check("rst_upd", int'(upd), 0);
      check("rst_new_age", int'(new_age), 0);
      check("rst_busy", int'(sweep_busy), 0);
      plca_reset = 1'b0;
      tick();

      for (int i = 0; i < 12; i++) begin
         dplca_aging     = (vecs[i].ag != 0);
         to_end          = (vecs[i].te != 0);
         to_used         = (vecs[i].tu != 0);
         to_id           = 8'(vecs[i].id);
         plca_node_count = 8'(vecs[i].nc);
         cycle_end       = (vecs[i].ce != 0);
         tick();
         to_end = 1'b0; to_used = 1'b0; cycle_end = 1'b0;
         check($sformatf("vec%0d_upd", i), int'(upd), vecs[i].e_upd);
         check($sformatf("vec%0d_new_age", i), int'(new_age), vecs[i].e_na);
         check($sformatf("vec%0d_busy", i), int'(sweep_busy), 0);
         check($sformatf("vec%0d_nz", i), nz_count(tab), vecs[i].e_nz);
         check($sformatf("vec%0d_entry%0d", i, vecs[i].c_idx),
               entry(tab, vecs[i].c_idx), vecs[i].c_val);
      end
      plca_node_count = 8'd8;

      // Window 1: id 3 used; sweep keeps it HARD
      record(3);
      check("rec3_entry", entry(tab, 3), 2);
      window(15, 0, "w1");
      do_sweep(-1, -1, "s1");
      check("s1_entry3", entry(tab, 3), 2);
      check("s1_nz", nz_count(tab), 1);
      to_end = 1'b1; to_used = 1'b0; to_id = 8'd0;
      tick();
      to_end = 1'b0;
      check("new_age_clear_on_to_end", int'(new_age), 0);
      check("to_unused_nz", nz_count(tab), 1);

      // Window 2: id 3 unused -> SOFT; id 5 recorded in the clock the sweep handles index 5
      window(15, 0, "w2");
      do_sweep(6, -1, "s2");
      check("s2_entry3", entry(tab, 3), 1);
      check("s2_entry5", entry(tab, 5), 2);
      check("s2_nz", nz_count(tab), 2);

      // Window 3: id 3 -> FREE, id 5 survives; extra cycle_end mid-sweep
      window(15, 1, "w3");
      do_sweep(-1, 100, "s3");
      check("s3_entry3", entry(tab, 3), 0);
      check("s3_entry5", entry(tab, 5), 2);
      check("s3_nz", nz_count(tab), 1);

      // Injected cycle_end left age_cnt at 1: 14 ordinary cycles, then a boundary
      window(14, 1, "w4");
      cycle_end = 1'b1;
      tick();
      cycle_end = 1'b0;
      check("w4_boundary_busy", int'(sweep_busy), 1);
      check("w4_boundary_upd", int'(upd), 0);

      // Aging dropped mid-sweep
      repeat (20) tick();
      dplca_aging = 1'b0;
      tick();
      check("aging_off_nz", nz_count(tab), 0);
      check("aging_off_busy", int'(sweep_busy), 0);
      check("aging_off_upd", int'(upd), 0);
      check("aging_off_new_age", int'(new_age), 0);
      dplca_aging = 1'b1;

      // Reset asserted mid-sweep
      record(2);
      window(15, 0, "w5");
      cycle_end = 1'b1;
      tick();
      cycle_end = 1'b0;
      check("w5_boundary_busy", int'(sweep_busy), 1);
      repeat (50) tick();
      check("pre_rst_entry2", entry(tab, 2), 2);
      #2;
      plca_reset = 1'b1;
      #1;
      check("async_rst_nz", nz_count(tab), 0);
      check("async_rst_busy", int'(sweep_busy), 0);
      check("async_rst_upd", int'(upd), 0);
      check("async_rst_new_age", int'(new_age), 0);
      tick();
      tick();
      plca_reset = 1'b0;
      tick();
      check("post_rst_busy", int'(sweep_busy), 0);
      check("post_rst_nz", nz_count(tab), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
